usb_bit_timer: RTL
==================

// Module: usb_bit_timer
// PURPOSE
//  Parametrised successor to bit_pd_counter. Generates USB bit-period timing for the transmitter
//  from an arbitrary system clock. Supports non-integer clock/bit ratios by fractional error
//  accumulation: at 100 MHz, FS gives a repeating period pattern of 8,8,9.
//  Selects full-speed (FS) or low-speed (LS) at run time, adds a mid-bit strobe, and counts bits
//  within a word. Sits between the TX control FSM and the NRZI/bit-stuff shifter.
// PARAMETERS
//  CLK_KHZ        100000  system clock frequency in kHz
//  FS_KHZ         12000   full-speed bit rate in kHz
//  LS_KHZ         1500    low-speed bit rate in kHz
//  BITS_PER_WORD  8       bits per word; bit_idx wraps here (>=2)
// PORTS
//  clk          in   1                      system clock, rising edge
//  rst          in   1                      async reset, active-high
//  en           in   1                      run enable; low = freeze all state
//  resync       in   1                      sync restart at start of bit 0
//  ls_mode      in   1                      1 = LS rate, 0 = FS rate
//  bit_strobe   out  1                      1-cycle pulse at end of each bit period
//  mid_strobe   out  1                      1-cycle pulse at bit mid-point
//  bit_idx      out  $clog2(BITS_PER_WORD)  index of the current bit in the word
//  word_strobe  out  1                      1-cycle pulse coincident with bit_strobe of last bit
// BEHAVIOUR
//  - Derived constants, per mode M in {FS,LS}:
//      BASE_M = CLK_KHZ / M_KHZ
//      REM_M  = CLK_KHZ % M_KHZ
//  - Elaboration error if BASE_M < 4.
//  - State:
//      cnt   counts 0..P-1, where P is the current period
//      err   counts 0..M_KHZ-1
//      bit_idx
//      latched mode
//  - Reset (async, rst=1): cnt=0, err=0, bit_idx=0, all strobes 0.
//      Mode is latched from ls_mode on the first enabled edge after reset.
//  - Period load, at each bit boundary and on resync:
//      s = err + REM_M
//      if s >= M_KHZ: P = BASE_M + 1, err <= s - M_KHZ
//      else:          P = BASE_M,     err <= s
//  - en=1: cnt increments each edge.
//      At cnt == P-1: cnt <= 0, bit_strobe registered high for the next cycle,
//      bit_idx advances, and the next period loads.
//  - mid_strobe: registered high for the cycle after the edge where cnt == P/2 (floor).
//  - Strobe spacing: consecutive bit_strobe pulses are exactly P clocks apart.
//      First pulse: the cycle after the P-th enabled edge following resync or reset.
//  - bit_idx: increments on each bit end; wraps BITS_PER_WORD-1 -> 0.
//      word_strobe is asserted in the same cycle as the bit_strobe that wraps it.
//  - en=0: cnt, err, bit_idx and mode hold; strobes deassert next cycle.
//      Timing resumes seamlessly when en returns high.
//  - resync=1 (priority over en):
//      cnt <= 0, err <= 0, bit_idx <= 0, mode <= ls_mode, strobes 0 next cycle.
//      Period loaded as if at start of bit 0.
//  - ls_mode change mid-bit: ignored until the next bit boundary.
//      At that boundary the new mode latches, err <= 0, and the period computes from the new mode.
//  - No combinational path from inputs to outputs; all outputs are registered.
// STRUCTURE
//  - Package usb_tx_pkg:
//      typedef enum logic {SPD_FS, SPD_LS} usb_speed_t
//      function calc_base(clk_khz, rate_khz)
//      function calc_rem(clk_khz, rate_khz)
//  - Sub-module usb_frac_period: holds err; on load pulse outputs P and next err for the
//      selected mode. Combinational P, registered err.
//  - Top: cnt, bit_idx, mode latch, strobe registers.
// TESTING
//  1. Reset: rst=1 mid-count with en=1 -> all outputs 0 immediately (async), cnt=0.
//  2. FS, 100 MHz, en=1 for 30 bits -> strobe gaps 8,8,9 repeating, 25 clocks per 3 bits;
//     mid_strobe at cnt 4,4,4; word_strobe every 8th bit_strobe.
//  3. LS, 100 MHz -> gaps 66,67,67 repeating (200 clocks per 3 bits);
//     1000 bits take exactly 66667 clocks (+/-1).
//  4. en low for 13 cycles mid-bit (cnt=3, FS) -> no strobes; next bit_strobe 13 cycles later
//     than unpaused; bit_idx unchanged.
//  5. ls_mode 0->1 at cnt=2 of bit 5 -> bit 5 ends at FS length; bit 6 is 66 clocks; bit_idx 6.
//  6. resync asserted with en=1 at bit_idx=5 -> next cycle strobes 0, bit_idx=0;
//     first bit_strobe 8 clocks later (FS).

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared types and elaboration-time helpers for the USB transmit timing blocks.
package usb_tx_pkg;

    typedef enum logic {SPD_FS = 1'b0, SPD_LS = 1'b1} usb_speed_t;

    function automatic int calc_base(input int clk_khz, input int rate_khz);
        return clk_khz / rate_khz;
    endfunction

    function automatic int calc_rem(input int clk_khz, input int rate_khz);
        return clk_khz % rate_khz;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/usb_frac_period.sv
// Fractional bit-period generator: combinational period for the current bit from the
// accumulated error, error register advanced at each bit boundary.
module usb_frac_period
    import usb_tx_pkg::*;
#(
    parameter int CLK_KHZ = 100000,
    parameter int FS_KHZ  = 12000,
    parameter int LS_KHZ  = 1500,
    parameter int PER_W   = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             clr_i,
    input  usb_speed_t       mode_i,
    output logic [PER_W-1:0] per_o
);

    localparam int ERR_W = $clog2(2 * max2(FS_KHZ, LS_KHZ) + 1);

    localparam logic [ERR_W-1:0] RATE_FS = ERR_W'(FS_KHZ);
    localparam logic [ERR_W-1:0] RATE_LS = ERR_W'(LS_KHZ);
    localparam logic [ERR_W-1:0] REM_FS  = ERR_W'(calc_rem(CLK_KHZ, FS_KHZ));
    localparam logic [ERR_W-1:0] REM_LS  = ERR_W'(calc_rem(CLK_KHZ, LS_KHZ));
    localparam logic [PER_W-1:0] BASE_FS = PER_W'(calc_base(CLK_KHZ, FS_KHZ));
    localparam logic [PER_W-1:0] BASE_LS = PER_W'(calc_base(CLK_KHZ, LS_KHZ));

    logic [ERR_W-1:0] err_q, err_d, err_ld;
    logic [ERR_W-1:0] rate, rem, sum;
    logic [PER_W-1:0] base;

    always_comb begin
        rate  = (mode_i == SPD_LS) ? RATE_LS : RATE_FS;
        rem   = (mode_i == SPD_LS) ? REM_LS  : REM_FS;
        base  = (mode_i == SPD_LS) ? BASE_LS : BASE_FS;
        sum   = err_q + rem;
        // Once the accumulated fraction reaches a whole clock, this bit gets one extra cycle.
        if (sum >= rate) begin
            per_o  = base + PER_W'(1);
            err_ld = sum - rate;
        end else begin
            per_o  = base;
            err_ld = sum;
        end
        err_d = err_q;
        if (clr_i) begin
            err_d = '0;
        end else if (load_i) begin
            err_d = err_ld;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/usb_bit_timer.sv
// USB TX bit-period timer: bit/mid/word strobes and bit index for FS or LS signalling
// from an arbitrary system clock.
module usb_bit_timer
    import usb_tx_pkg::*;
#(
    parameter int CLK_KHZ       = 100000,
    parameter int FS_KHZ        = 12000,
    parameter int LS_KHZ        = 1500,
    parameter int BITS_PER_WORD = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             resync,
    input  logic                             ls_mode,
    output logic                             bit_strobe,
    output logic                             mid_strobe,
    output logic [$clog2(BITS_PER_WORD)-1:0] bit_idx,
    output logic                             word_strobe
);

    localparam int BASE_FS = calc_base(CLK_KHZ, FS_KHZ);
    localparam int BASE_LS = calc_base(CLK_KHZ, LS_KHZ);
    localparam int PER_W   = $clog2(max2(BASE_FS, BASE_LS) + 2);
    localparam int IDX_W   = $clog2(BITS_PER_WORD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BITS_PER_WORD - 1);

    if (BASE_FS < 4 || BASE_LS < 4) begin : g_base_chk
        $error("usb_bit_timer: system clock must be at least 4x each bit rate");
    end
    if (BITS_PER_WORD < 2) begin : g_bpw_chk
        $error("usb_bit_timer: BITS_PER_WORD must be at least 2");
    end

    usb_speed_t       mode_q, mode_d, mode_in, mode_eff;
    logic             started_q, started_d;
    logic [PER_W-1:0] cnt_q, cnt_d, per;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             bit_q, bit_d, mid_q, mid_d, word_q, word_d;
    logic             bit_end, mid_hit, mode_chg;

    // Before the first enabled edge the mode is still unlatched, so the live input decides.
    assign mode_in  = usb_speed_t'(ls_mode);
    assign mode_eff = started_q ? mode_q : mode_in;
    assign bit_end  = (cnt_q == per - PER_W'(1));
    assign mid_hit  = (cnt_q == (per >> 1));
    assign mode_chg = bit_end && (mode_in != mode_eff);

    usb_frac_period #(
        .CLK_KHZ (CLK_KHZ),
        .FS_KHZ  (FS_KHZ),
        .LS_KHZ  (LS_KHZ),
        .PER_W   (PER_W)
    ) u_frac (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (en && bit_end),
        .clr_i   (resync || (en && mode_chg)),
        .mode_i  (mode_eff),
        .per_o   (per)
    );

    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        mode_d    = mode_q;
        started_d = started_q;
        bit_d     = 1'b0;
        mid_d     = 1'b0;
        word_d    = 1'b0;
        if (resync) begin
            cnt_d     = '0;
            idx_d     = '0;
            mode_d    = mode_in;
            started_d = 1'b1;
        end else if (en) begin
            started_d = 1'b1;
            mode_d    = mode_eff;
            bit_d     = bit_end;
            mid_d     = mid_hit;
            word_d    = bit_end && (idx_q == IDX_LAST);
            if (bit_end) begin
                cnt_d  = '0;
                mode_d = mode_in;
                idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_d = cnt_q + PER_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            mode_q    <= SPD_FS;
            started_q <= 1'b0;
            bit_q     <= 1'b0;
            mid_q     <= 1'b0;
            word_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            mode_q    <= mode_d;
            started_q <= started_d;
            bit_q     <= bit_d;
            mid_q     <= mid_d;
            word_q    <= word_d;
        end
    end

    assign bit_strobe  = bit_q;
    assign mid_strobe  = mid_q;
    assign word_strobe = word_q;
    assign bit_idx     = idx_q;

endmodule
